in_module: RTL and testbench

Input-port bank for the byter CPU, the read-side counterpart of the output register bank. It samples 16 external 8-bit input ports through a per-port synchronizer and returns the addressed port's value to the CPU data path one cycle after a read strobe. Optionally, it tracks per-port change flags and raises an interrupt request when any port value changes.

---
 rtl/in_module_if.sv | 13 +
 rtl/in_module.sv | 103 ++++++++++
 tb/tb_in_module.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/in_module_if.sv
// Read-side bus of the input-port bank: read strobe/address in, registered data,
// valid pulse, sticky change flags and interrupt request out.
interface in_module_if;
  logic        enable;
  logic [3:0]  addr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [15:0] changed;
  logic        irq;

  modport master (output enable, addr, input out_data, out_valid, changed, irq);
  modport slave  (input enable, addr, output out_data, out_valid, changed, irq);
endinterface

// File: rtl/in_module.sv
// Input-port bank: 16 synchronized 8-bit ports read back one cycle after a strobe.
// Optional per-port change flags and irq are built when IN_MODULE_CHANGE_EN is defined.
module in_module_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES:1][W-1:0] s;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s <= '0;
    end else begin
      s[1] <= d;
      for (int k = 2; k <= STAGES; k++) s[k] <= s[k-1];
    end
  end

  assign q = s[STAGES];
endmodule

module in_module #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_00, in_01, in_02, in_03,
  input  logic [7:0]  in_04, in_05, in_06, in_07,
  input  logic [7:0]  in_08, in_09, in_10, in_11,
  input  logic [7:0]  in_12, in_13, in_14, in_15,
  in_module_if.slave  bus
);
  localparam int NUM_PORTS = 16;

  logic [NUM_PORTS-1:0][7:0] pins;
  logic [NUM_PORTS-1:0][7:0] vis;

  assign pins = {in_15, in_14, in_13, in_12, in_11, in_10, in_09, in_08,
                 in_07, in_06, in_05, in_04, in_03, in_02, in_01, in_00};

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    in_module_sync #(.W(8), .STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pins[g]),
      .q     (vis[g])
    );
  end

  // Read path: data holds between reads, valid is a one-cycle pulse per strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_data  <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.enable;
      if (bus.enable) bus.out_data <= vis[bus.addr];
    end
  end

`ifdef IN_MODULE_CHANGE_EN
  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [NUM_PORTS-1:0][7:0] prev;
  logic [2:0]                warm;
  logic                      warm_done;
  logic [NUM_PORTS-1:0]      changed_q, set_v, clr_v;

  assign warm_done = (warm == WARM_MAX);

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      set_v[i] = warm_done && (vis[i] != prev[i]);
      clr_v[i] = bus.enable && (bus.addr == 4'(i));
    end
  end

  // Set beats clear so a change landing on the read edge is never lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev      <= '0;
      warm      <= '0;
      changed_q <= '0;
    end else begin
      prev      <= vis;
      if (!warm_done) warm <= warm + 3'd1;
      changed_q <= set_v | (changed_q & ~clr_v);
    end
  end

  assign bus.changed = changed_q;
  assign bus.irq     = |changed_q;
`else
  assign bus.changed = 16'h0000;
  assign bus.irq     = 1'b0;
`endif
endmodule

// File: tb/tb_in_module.sv
// Directed bench for in_module (SYNC_STAGES=2); change-flag sequences are
// compiled in only when IN_MODULE_CHANGE_EN is defined.
module tb_in_module;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pins [16];
  int checks = 0;
  int errors = 0;

  in_module_if bus ();

  in_module #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .in_00(pins[0]),  .in_01(pins[1]),  .in_02(pins[2]),  .in_03(pins[3]),
    .in_04(pins[4]),  .in_05(pins[5]),  .in_06(pins[6]),  .in_07(pins[7]),
    .in_08(pins[8]),  .in_09(pins[9]),  .in_10(pins[10]), .in_11(pins[11]),
    .in_12(pins[12]), .in_13(pins[13]), .in_14(pins[14]), .in_15(pins[15]),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [7:0] val;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a);
    bus.enable = 1'b1;
    bus.addr   = a;
    step();
    bus.enable = 1'b0;
  endtask

  initial begin
    vecs[0] = '{5,  8'hA5, 8'hA5};
    vecs[1] = '{0,  8'h00, 8'h00};
    vecs[2] = '{15, 8'h5A, 8'h5A};
    vecs[3] = '{9,  8'hFF, 8'hFF};
    vecs[4] = '{1,  8'h80, 8'h80};
    vecs[5] = '{14, 8'h01, 8'h01};

    reset = 1'b0;
    bus.enable = 1'b0;
    bus.addr = 4'd0;
    for (int i = 0; i < 16; i++) pins[i] = 8'hFF;
    step(3);
    chk("rst_data",    bus.out_data,  8'h00);
    chk("rst_valid",   bus.out_valid, 1'b0);
    chk("rst_changed", bus.changed,   16'h0000);
    chk("rst_irq",     bus.irq,       1'b0);

    // Synchronizer was flushed to 0: first two reads see 0, third sees the pins.
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.addr = 4'd0;
    step();
    chk("rel_rd1_data",  bus.out_data,  8'h00);
    chk("rel_rd1_valid", bus.out_valid, 1'b1);
    step();
    chk("rel_rd2_data",  bus.out_data,  8'h00);
    step();
    chk("rel_rd3_data",  bus.out_data,  8'hFF);
    bus.enable = 1'b0;
    step(5);
    chk("warm_changed", bus.changed,   16'h0000);
    chk("warm_irq",     bus.irq,       1'b0);
    chk("idle_valid",   bus.out_valid, 1'b0);

`ifdef IN_MODULE_CHANGE_EN
    pins[3] = 8'h00;
    pins[7] = 8'h00;
    step(4);
    chk("prep_changed", bus.changed, 16'h0088);
    rd(4'd3);
    rd(4'd7);
    step();
    chk("prep_clear", bus.changed, 16'h0000);

    pins[3] = 8'h3C;
    step(2);
    chk("chg_early", bus.changed, 16'h0000);
    step();
    chk("chg_set",     bus.changed, 16'h0008);
    chk("chg_irq",     bus.irq,     1'b1);
    rd(4'd3);
    chk("chg_rd_data", bus.out_data, 8'h3C);
    chk("chg_rd_clr",  bus.changed,  16'h0000);
    chk("chg_rd_irq",  bus.irq,      1'b0);

    // Read lands on the detection edge; the synchronized value is already new.
    pins[7] = 8'h77;
    step(2);
    rd(4'd7);
    chk("coll_flag", bus.changed[7], 1'b1);
    chk("coll_irq",  bus.irq,        1'b1);
    chk("coll_data", bus.out_data,   8'h77);
    rd(4'd7);
    chk("coll_clr",  bus.changed,    16'h0000);
`endif

    foreach (vecs[v]) begin
      pins[vecs[v].port] = vecs[v].val;
      step(3);
      rd(4'(vecs[v].port));
      chk($sformatf("vec%0d_data", v),  bus.out_data,  vecs[v].exp);
      chk($sformatf("vec%0d_valid", v), bus.out_valid, 1'b1);
`ifndef IN_MODULE_CHANGE_EN
      chk($sformatf("vec%0d_changed", v), {bus.irq, bus.changed}, 17'h0);
`endif
      step();
      chk($sformatf("vec%0d_drop", v), bus.out_valid, 1'b0);
      chk($sformatf("vec%0d_hold", v), bus.out_data,  vecs[v].exp);
    end

    pins[0]  = 8'h11;
    pins[15] = 8'hEE;
    step(3);
    bus.enable = 1'b1;
    bus.addr = 4'd0;
    step();
    chk("b2b_d0", bus.out_data,  8'h11);
    chk("b2b_v0", bus.out_valid, 1'b1);
    bus.addr = 4'd15;
    step();
    chk("b2b_d1", bus.out_data,  8'hEE);
    chk("b2b_v1", bus.out_valid, 1'b1);
    bus.enable = 1'b0;
    step();
    chk("b2b_end_valid", bus.out_valid, 1'b0);
    chk("b2b_end_data",  bus.out_data,  8'hEE);

    bus.enable = 1'b1;
    bus.addr = 4'd15;
    reset = 1'b0;
    step();
    chk("mid_valid",   bus.out_valid, 1'b0);
    chk("mid_data",    bus.out_data,  8'h00);
    chk("mid_changed", bus.changed,   16'h0000);
    chk("mid_irq",     bus.irq,       1'b0);
    bus.enable = 1'b0;
    reset = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
